// File: rtl/median_line_buffer.sv
// ---------------------------------------------------------------------------
// median_line_buffer
//
// Builds vertical 3-pixel windows from a raster pixel stream for the
// downstream 3-input median. Two line memories hold the previous two rows.
// For every pixel from row 2 onward the aligned triple (y-2, y-1, y) is
// presented one cycle after the pixel is accepted.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - pixel present on in_pix (no backpressure)
//   in_sof     - start of frame, marks the in_valid pixel as (0,0)
//   in_pix     - 8-bit input pixel
//   out_valid  - window valid strobe
//   val_0      - pixel (y-2, x)
//   val_1      - pixel (y-1, x)
//   val_2      - pixel (y, x)
//   out_sol    - window is at column 0
//   frame_done - pulse with the last window of the frame
//   state_dbg  - current FSM state (0 IDLE, 1 FILL, 2 STREAM)
//
// Handshake: a pixel is accepted on any rising edge where in_valid is high
// and either in_sof is high or a frame is in progress; there is no ready.
// out_valid is a single-cycle strobe, data outputs hold between strobes.
// ---------------------------------------------------------------------------
module median_line_buffer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pix,
    output logic       out_valid,
    output logic [7:0] val_0,
    output logic [7:0] val_1,
    output logic [7:0] val_2,
    output logic       out_sol,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sol_q, out_sol_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      val_0_q, val_0_d;
    logic [7:0]      val_1_q, val_1_d;
    logic [7:0]      val_2_q, val_2_d;

    // Line memories are deliberately not reset: FILL rewrites both rows
    // before any window is emitted.
    logic [7:0]      line_a_mem [IMG_W];
    logic [7:0]      line_b_mem [IMG_W];

    logic            start;
    logic            advance;
    logic            accept;
    logic            emit;
    logic            col_last;
    logic            row_last;
    logic [CW-1:0]   addr;

    always_comb begin
        // in_sof always restarts the frame, even on the last pixel of one.
        start    = in_valid && in_sof;
        advance  = in_valid && !in_sof && (state_q != S_IDLE);
        accept   = start || advance;
        emit     = advance && (state_q == S_STREAM);
        addr     = start ? '0 : col_q;
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = 1'b0;
        out_sol_d    = 1'b0;
        frame_done_d = 1'b0;
        val_0_d      = val_0_q;
        val_1_d      = val_1_q;
        val_2_d      = val_2_q;

        if (start) begin
            state_d = S_FILL;
            col_d   = CW'(1);
            row_d   = '0;
        end else if (advance) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (state_q == S_FILL && row_q == RW'(1) && col_last) begin
                state_d = S_STREAM;
            end
            if (state_q == S_STREAM && row_last && col_last) begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        end

        if (emit) begin
            // Memory reads here see the contents before this edge's write.
            out_valid_d  = 1'b1;
            val_0_d      = line_a_mem[addr];
            val_1_d      = line_b_mem[addr];
            val_2_d      = in_pix;
            out_sol_d    = (col_q == '0);
            frame_done_d = row_last && col_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            val_0_q      <= '0;
            val_1_q      <= '0;
            val_2_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_sol_q    <= out_sol_d;
            frame_done_q <= frame_done_d;
            val_0_q      <= val_0_d;
            val_1_q      <= val_1_d;
            val_2_q      <= val_2_d;
        end
    end

    // Row shift: line_b moves into line_a, new pixel into line_b.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_a_mem[addr] <= line_b_mem[addr];
            line_b_mem[addr] <= in_pix;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sol    = out_sol_q;
    assign frame_done = frame_done_q;
    assign val_0      = val_0_q;
    assign val_1      = val_1_q;
    assign val_2      = val_2_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_median_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_median_line_buffer
//
// Bench for median_line_buffer with IMG_W=4, IMG_H=4. A reference model
// keeps the current frame as a flat array indexed by raster position and
// derives each expected window from positions p-2W, p-W and p.
// ---------------------------------------------------------------------------
module tb_median_line_buffer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pix;
  logic       out_valid;
  logic [7:0] val_0;
  logic [7:0] val_1;
  logic [7:0] val_2;
  logic       out_sol;
  logic       frame_done;
  logic [1:0] state_dbg;

  median_line_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .val_0      (val_0),
    .val_1      (val_1),
    .val_2      (val_2),
    .out_sol    (out_sol),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [25:0] exp_q[$];       // {sol, done, v0, v1, v2}
  logic [7:0]  img[N];
  int          m_pos;
  bit          m_in_frame;
  logic [23:0] last_vals;
  int          n_checks;
  int          n_errors;
  int          dut_wins;
  int          model_wins;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, model update and output check.
  task automatic cycle(input logic v, input logic s, input logic [7:0] p);
    logic        exp_v;
    logic [25:0] w;
    in_valid = v;
    in_sof   = s;
    in_pix   = p;
    exp_v    = 1'b0;
    if (v && s) begin
      m_in_frame = 1'b1;
      img[0]     = p;
      m_pos      = 1;
    end else if (v && m_in_frame) begin
      img[m_pos] = p;
      if (m_pos >= 2 * W) begin
        exp_q.push_back({(m_pos % W) == 0, m_pos == N - 1,
                         img[m_pos - 2 * W], img[m_pos - W], p});
        exp_v = 1'b1;
        model_wins++;
      end
      m_pos++;
      if (m_pos == N) m_in_frame = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (out_valid) dut_wins++;
    check_eq("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      w = exp_q.pop_front();
      check_eq("window", 32'({out_sol, frame_done, val_0, val_1, val_2}), 32'(w));
      last_vals = w[23:0];
    end else begin
      check_eq("hold", 32'({out_sol, frame_done, val_0, val_1, val_2}), 32'({2'b00, last_vals}));
    end
  endtask

  task automatic reset_cycle(input logic v, input logic [7:0] p);
    rst_n    = 1'b0;
    in_valid = v;
    in_sof   = 1'b0;
    in_pix   = p;
    m_in_frame = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("reset_out", 32'({out_valid, out_sol, frame_done, val_0, val_1, val_2}), 32'd0);
    last_vals = '0;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'($urandom_range(1)), 8'($urandom));
  endtask

  // Send raster positions [first, stop) with optional random gaps.
  task automatic send_pixels(input int first, input int stop, input int off,
                             input bit sof_first, input int gap_pct, input bit rnd);
    logic [7:0] p;
    for (int i = first; i < stop; i++) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(99) < gap_pct) idle_cycle();
      end
      p = rnd ? 8'($urandom) : 8'(((i / W) * 16 + (i % W) + off) & 8'hff);
      cycle(1'b1, (i == first) && sof_first, p);
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq(tag, 32'(dut_wins), 32'(model_wins));
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    dut_wins   = 0;
    model_wins = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    dut_wins   = 0;
    model_wins = 0;
    m_pos      = 0;
    m_in_frame = 1'b0;
    last_vals  = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sof     = 1'b0;
    in_pix     = '0;

    // 1: reset then a clean frame
    reset_cycle(1'b0, 8'h00);
    reset_cycle(1'b1, 8'h55);
    send_pixels(0, N, 0, 1'b1, 0, 1'b0);
    check_eq("frame1_wins", 32'(model_wins), 32'((H - 2) * W));
    check_counts("s1_count");
    idle_cycle();

    // 2: pixels without sof are ignored, then a normal frame
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom));
    check_counts("s2_stray");
    send_pixels(0, N, 0, 1'b1, 0, 1'b0);
    check_counts("s2_count");

    // 3: random gaps
    send_pixels(0, N, 0, 1'b1, 50, 1'b0);
    idle_cycle();
    check_counts("s3_count");

    // 4: abort at (2,2), then frame offset by 0x80
    send_pixels(0, 10, 0, 1'b1, 0, 1'b0);
    check_eq("s4_partial", 32'(model_wins), 32'd2);
    send_pixels(0, N, 8'h80, 1'b1, 0, 1'b0);
    check_counts("s4_count");

    // 5: reset at (3,1), remaining pixels ignored, then a clean frame
    send_pixels(0, 13, 0, 1'b1, 0, 1'b0);
    reset_cycle(1'b1, 8'h31);
    send_pixels(14, N, 0, 1'b0, 0, 1'b0);
    send_pixels(0, N, 0, 1'b1, 0, 1'b0);
    check_counts("s5_count");

    // 6: back-to-back frames
    send_pixels(0, N, 0, 1'b1, 0, 1'b0);
    send_pixels(0, N, 8'h40, 1'b1, 0, 1'b0);
    check_counts("s6_count");

    // 7: sof coincident with the last pixel position wins
    send_pixels(0, N - 1, 0, 1'b1, 0, 1'b0);
    send_pixels(0, N, 8'h20, 1'b1, 0, 1'b0);
    check_counts("s7_count");

    // 8: random frames, random gaps, occasional early restart
    for (int f = 0; f < 12; f++) begin
      send_pixels(0, ($urandom_range(3) == 0) ? int'($urandom_range(N - 1, 1)) : N,
                  0, 1'b1, 30, 1'b1);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    send_pixels(0, N, 0, 1'b1, 30, 1'b1);
    idle_cycle();
    check_counts("s8_count");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/median_line_buffer.md
# median_line_buffer

Raster-stream line buffer that builds the vertical 3-pixel windows consumed by the 3-input median filter. It accepts one 8-bit pixel per cycle in raster order and stores the two previous image rows. For every pixel from row 2 onward, it emits the vertically aligned triple (row y-2, row y-1, row y) on `val_0`/`val_1`/`val_2`. It sits directly upstream of `median` in the filtering datapath.

## Interface
- `IMG_W`, default 64: pixels per row, ≥ 2.
- `IMG_H`, default 64: rows per frame, ≥ 3.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  pixel present on `in_pix` this cycle; there is no backpressure.
- `in_sof`  input  1  start of frame; qualifies the `in_valid` pixel as (row 0, col 0).
- `in_pix`  input  8  input pixel.
- `out_valid`  output  1  window valid.
- `val_0`  output  8  pixel at (y-2, x), the oldest row.
- `val_1`  output  8  pixel at (y-1, x).
- `val_2`  output  8  pixel at (y, x), the current input.
- `out_sol`  output  1  window is at column 0.
- `frame_done`  output  1  one-cycle pulse with the last window of the frame.

## Operation
- Storage: two line memories, `line_a` (row y-2) and `line_b` (row y-1), each `IMG_W` x 8. They are not reset.
- On an accepted pixel at column c:
  - read `line_a[c]` and `line_b[c]`;
  - write `line_a[c] <= line_b[c]` and `line_b[c] <= in_pix`.
  - Read-before-write semantics are required.
- Counters:
  - `col` runs 0..IMG_W-1 and wraps to 0.
  - `row` increments on each col wrap and runs 0..IMG_H-1.
- FSM:
  - IDLE: ignore all `in_valid` without `in_sof`. On `in_valid && in_sof`, accept the pixel as (0,0), set col=1 and row=0, and go to FILL.
  - FILL (rows 0–1): store pixels, `out_valid`=0. Go to STREAM when the pixel (1, IMG_W-1) is accepted.
  - STREAM (rows 2..IMG_H-1): each accepted pixel produces one window. On accepting (IMG_H-1, IMG_W-1), assert `frame_done` with that window and go to IDLE.
- `in_sof` with `in_valid` in FILL or STREAM: abort the current frame, treat the pixel as (0,0) of a new frame, and go to FILL. No window is produced for this pixel. Stale line contents are never emitted, because FILL rewrites both lines before STREAM.
- `in_valid`=0 stalls all counters; gaps are allowed anywhere.
- Total windows per frame: (IMG_H-2)·IMG_W.

## Timing
- Reset (while `rst_n`=0 at the clock edge):
  - state=IDLE, col=0, row=0;
  - `out_valid`=0, `val_0`/`val_1`/`val_2`=0, `out_sol`=0, `frame_done`=0.
- Reset mid-frame discards the frame. After release, output resumes only after the next `in_sof`.
- Latency: 1 cycle. The window for the pixel accepted at edge N is on the outputs after edge N and is held until the next accepted pixel.
- `out_valid`, `out_sol` and `frame_done` are single-cycle strobes. They are 0 in any cycle following a non-accepted input.
- Data outputs hold their last value when `out_valid`=0.
- Simultaneous `in_sof` and the last pixel of a frame: `in_sof` wins. There is no window and no `frame_done`.
- Downstream `median` adds 1 more cycle, so pixel in to median out is 2 cycles.

## Test plan
Stimulus uses IMG_W=4, IMG_H=4, pixel value = row·16+col, and continuous `in_valid` unless stated.

- Reset then full frame → no `out_valid` for the first 8 pixels. Windows 1..8 follow, one cycle after each pixel. The window for (2,1) is `val_0`=0x01, `val_1`=0x11, `val_2`=0x21. `out_sol` is set on (2,0) and (3,0). `frame_done` pulses once with window (3,3) = 0x13/0x23/0x33.
- Pixels without `in_sof` after reset → all ignored, `out_valid` stays 0. A following frame with `in_sof` behaves as in scenario 1.
- Random `in_valid` gaps (≈50% duty) over the full frame → same 8 windows with identical values and no duplicates. Outputs are held during gaps.
- `in_sof` at (2,2) of frame 1, then a full frame 2 with values +0x80 → frame 1 emits only windows (2,0) and (2,1). Frame 2 emits 8 windows with no frame-1 values; the first is 0x80/0x90/0xA0.
- `rst_n` low for 1 cycle at (3,1) → outputs are 0 the next cycle. No windows appear until the next `in_sof` frame, which completes normally.
- Back-to-back frames with `in_sof` on the cycle after frame 1's last pixel → `frame_done` is followed by 8 fill cycles with `out_valid`=0, then 8 correct windows.
